vga_rect_fill: RTL and testbench
================================

# vga_rect_fill

Bus-mapped hardware rectangle-fill engine that sits directly upstream of the frame buffer's write port (port A). The processor programs two corner coordinates and a colour through a small register bank on the shared 8-bit data bus, then writes a start bit. The engine then writes one pixel per clock into the 160x120 one-bit frame buffer, raising BUSY while it owns the port. The top level muxes frame-buffer port A between this engine (when BUSY=1) and the VGA register bank.

## Interface
- `BaseAddr`, 8'hC0: bus address of register 0; the block decodes BaseAddr..BaseAddr+4.
- `X_MAX`, 159: largest legal X coordinate.
- `Y_MAX`, 119: largest legal Y coordinate.
- `CLK` input, 1: system clock; the block uses this one clock only.
- `RESET` input, 1: synchronous, active-high reset.
- `BUS_DATA` inout, 8: shared data bus, tristated when the block is not driving it.
- `BUS_ADDR` input, 8: bus address.
- `BUS_WE` input, 1: 1 = processor write, 0 = processor read.
- `FB_ADDR` output, 15: frame-buffer address, {y[6:0], x[7:0]}.
- `FB_DATA` output, 1: pixel colour to write.
- `FB_WE` output, 1: frame-buffer write strobe.
- `BUSY` output, 1: high while the block owns port A.

## Operation
- **Register map (offset from BaseAddr):**
  - 0: X0
  - 1: Y0[6:0]
  - 2: X1
  - 3: Y1[6:0]
  - 4 write: bit0 = colour, bit1 = start
  - 4 read: {BUSY, DONE, 5'b0, colour}
- **Bus writes:** a write is accepted when the address is in range and BUS_WE=1. Writes to offsets 0–4 are ignored while BUSY=1.
- **Bus reads:** when the address is in range and BUS_WE=0, the block drives the registered read data onto the bus one cycle later. Otherwise BUS_DATA stays at Z.
- **FSM states:** IDLE → CLIP → FILL → IDLE.
  - IDLE: a write to offset 4 with bit1=1 latches the colour, clears DONE and moves to CLIP.
  - CLIP, one cycle:
    - xa = min(X0,X1), xb = max(X0,X1); same for Y.
    - Clamp xa and xb to X_MAX, ya and yb to Y_MAX.
    - Load the pixel counters cx=xa, cy=ya.
  - FILL: writes one pixel per cycle in raster order, X innermost.
    - When cx==xb, cx reloads xa and cy increments.
    - When cx==xb and cy==yb, the FSM returns to IDLE and sets DONE.
- **Pixel count:** (xb−xa+1)·(yb−ya+1). A degenerate rectangle (X0==X1, Y0==Y1) writes exactly one pixel.
- **Start while busy:** ignored, with no restart.
- **DONE:** sticky; cleared only by a new start or by RESET.
- **Outputs:** FB_WE=1 only in FILL. FB_DATA is the latched colour. BUSY=1 in CLIP and FILL.
- **Counter widths:** 8-bit X, 7-bit Y. Clamping guarantees no wrap-around.
- **Reset values:** FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0, DONE=0, all registers 0, FSM in IDLE, bus released.

## Timing
- Start write sampled at edge N:
  - CLIP during cycle N+1.
  - First FB_WE=1 during cycle N+2 with FB_ADDR={ya,xa}.
- The last pixel is written during cycle N+1+P, where P is the pixel count.
- BUSY falls and DONE rises on the same edge.
- FB_ADDR, FB_DATA and FB_WE are all registered; they change together on the rising edge.
- A bus read of offset 4 at edge M returns the status as sampled at edge M, driven during M+1.
- RESET asserted mid-FILL: FB_WE=0 and BUSY=0 after the next edge, and no further pixels are written.
- Throughput is fixed at 1 pixel/cycle, with no stalls; the top-level mux gives the engine priority while BUSY=1.

## Structure
- **Shared package `vga_pkg`:**
  - Constants X_MAX, Y_MAX, frame-buffer address width 15.
  - Register offsets: REG_X0..REG_CTRL.
  - FSM state encoding: IDLE, CLIP, FILL.
- **Sub-module `rect_scan_counter`:** nested X/Y counter with load (xa, ya, xb, yb), an enable input and a last-pixel flag.
- **Top level:** bus decode, register bank, FSM and tristate driver.

## Test plan
- Write X0=2, Y0=3, X1=4, Y1=4, ctrl=8'h03 → 6 FB_WE pulses at addresses {3,2},{3,3},{3,4},{4,2},{4,3},{4,4}, FB_DATA=1; status read afterwards returns 8'h41.
- X0=10, X1=5, Y0=Y1=0 (swapped corners) → FB_ADDR sequence x=5..10 at y=0, exactly 6 writes.
- X0=150, X1=200, Y0=118, Y1=127 → clamped to x=150..159, y=118..119, giving 20 writes with none outside range.
- During a fill: write X0=0, then rewrite ctrl with start=1 → both ignored; the write count matches the original rectangle and X0 still reads back the old value.
- Assert RESET for 1 cycle at the 3rd pixel of a 4x4 fill → FB_WE low on the following cycle, BUSY=0, status reads 8'h00.
- Read offset 4 while BUS_ADDR is outside BaseAddr..BaseAddr+4 → BUS_DATA stays Z. Read while busy → bit7=1.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA rectangle-fill engine:
//   - frame-buffer geometry (X_MAX, Y_MAX, FB_ADDR_W)
//   - register offsets of the fill engine's bus register bank
//   - FSM state encoding
//   - small min/max/clamp helpers used by the corner-sorting logic
package vga_pkg;

    localparam int X_MAX     = 159;
    localparam int Y_MAX     = 119;
    localparam int FB_ADDR_W = 15;

    localparam logic [2:0] REG_X0   = 3'd0;
    localparam logic [2:0] REG_Y0   = 3'd1;
    localparam logic [2:0] REG_X1   = 3'd2;
    localparam logic [2:0] REG_Y1   = 3'd3;
    localparam logic [2:0] REG_CTRL = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2
    } fill_state_t;

    function automatic logic [7:0] min_x(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max_x(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [6:0] min_y(input logic [6:0] a, input logic [6:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [6:0] max_y(input logic [6:0] a, input logic [6:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] clamp_x(input logic [7:0] v);
        return (v > 8'(X_MAX)) ? 8'(X_MAX) : v;
    endfunction

    function automatic logic [6:0] clamp_y(input logic [6:0] v);
        return (v > 7'(Y_MAX)) ? 7'(Y_MAX) : v;
    endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter
// Nested X/Y pixel counter that walks a rectangle in raster order (X innermost).
// Ports:
//   CLK, RESET   - clock, synchronous active-high reset
//   load         - capture bounds and set cx=xa, cy=ya
//   enable       - advance one pixel this cycle
//   xa, xb       - inclusive X bounds (xa <= xb)
//   ya, yb       - inclusive Y bounds (ya <= yb)
//   cx, cy       - current pixel position (registered)
//   last         - current position is the final pixel (cx==xb and cy==yb)
module rect_scan_counter
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] xa,
    input  logic [7:0] xb,
    input  logic [6:0] ya,
    input  logic [6:0] yb,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);

    logic [7:0] xa_reg;
    logic [7:0] xb_reg;
    logic [6:0] yb_reg;
    logic [7:0] cx_reg;
    logic [6:0] cy_reg;

    logic row_end;

    assign row_end = (cx_reg == xb_reg);
    assign last    = row_end && (cy_reg == yb_reg);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            xa_reg <= 8'd0;
            xb_reg <= 8'd0;
            yb_reg <= 7'd0;
            cx_reg <= 8'd0;
            cy_reg <= 7'd0;
        end else if (load) begin
            xa_reg <= xa;
            xb_reg <= xb;
            yb_reg <= yb;
            cx_reg <= xa;
            cy_reg <= ya;
        end else if (enable && !last) begin
            // Hold on the final pixel so the address bus rests inside the
            // rectangle after the fill instead of stepping one row past it.
            if (row_end) begin
                cx_reg <= xa_reg;
                cy_reg <= cy_reg + 7'd1;
            end else begin
                cx_reg <= cx_reg + 8'd1;
            end
        end
    end

    assign cx = cx_reg;
    assign cy = cy_reg;

endmodule

// File: rtl/vga_rect_fill.sv
// vga_rect_fill
// Bus-mapped rectangle-fill engine driving frame-buffer port A.
// The processor writes two corners and a colour, then sets the start bit;
// the engine writes one pixel per clock into the 160x120 one-bit frame buffer.
// Register map (offset from BaseAddr):
//   0 X0, 1 Y0[6:0], 2 X1, 3 Y1[6:0]
//   4 write: bit0 colour, bit1 start; 4 read: {BUSY, DONE, 5'b0, colour}
// Ports:
//   CLK, RESET - clock, synchronous active-high reset
//   BUS_DATA   - shared 8-bit data bus (driven only the cycle after a read)
//   BUS_ADDR   - bus address
//   BUS_WE     - 1 = write, 0 = read
//   FB_ADDR    - frame-buffer address {y[6:0], x[7:0]}
//   FB_DATA    - pixel colour
//   FB_WE      - frame-buffer write strobe
//   BUSY       - engine owns port A (CLIP or FILL)
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter logic [7:0] BaseAddr = 8'hC0
)
(
    input  logic                 CLK,
    input  logic                 RESET,
    inout  wire  [7:0]           BUS_DATA,
    input  logic [7:0]           BUS_ADDR,
    input  logic                 BUS_WE,
    output logic [FB_ADDR_W-1:0] FB_ADDR,
    output logic                 FB_DATA,
    output logic                 FB_WE,
    output logic                 BUSY
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [7:0] offset_full;
    logic [2:0] offset;
    logic       in_range;
    logic       wr_en;
    logic       rd_en;
    logic       start;

    fill_state_t state_reg;
    fill_state_t state_next;

    logic busy;

    // Subtracting first keeps the range test correct even if BaseAddr sits
    // near the top of the address space.
    assign offset_full = BUS_ADDR - BaseAddr;
    assign offset      = offset_full[2:0];
    assign in_range    = (BUS_ADDR >= BaseAddr) && (offset_full <= 8'd4);
    assign busy        = (state_reg != IDLE);
    assign wr_en       = in_range && BUS_WE && !busy;
    assign rd_en       = in_range && !BUS_WE;
    assign start       = wr_en && (offset == REG_CTRL) && BUS_DATA[1];

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    logic [7:0] x0_reg;
    logic [6:0] y0_reg;
    logic [7:0] x1_reg;
    logic [6:0] y1_reg;
    logic       colour_reg;
    logic       done_reg;
    logic       fill_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x0_reg     <= 8'd0;
            y0_reg     <= 7'd0;
            x1_reg     <= 8'd0;
            y1_reg     <= 7'd0;
            colour_reg <= 1'b0;
        end else if (wr_en) begin
            case (offset)
                REG_X0:   x0_reg     <= BUS_DATA;
                REG_Y0:   y0_reg     <= BUS_DATA[6:0];
                REG_X1:   x1_reg     <= BUS_DATA;
                REG_Y1:   y1_reg     <= BUS_DATA[6:0];
                REG_CTRL: colour_reg <= BUS_DATA[0];
                default:  ;
            endcase
        end
    end

    // DONE is sticky: only a new start or reset clears it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            done_reg <= 1'b0;
        end else if (start) begin
            done_reg <= 1'b0;
        end else if (fill_done) begin
            done_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Corner sorting and clamping (evaluated during CLIP; the corner
    // registers cannot change while busy)
    // ------------------------------------------------------------------
    logic [7:0] xa;
    logic [7:0] xb;
    logic [6:0] ya;
    logic [6:0] yb;

    assign xa = clamp_x(min_x(x0_reg, x1_reg));
    assign xb = clamp_x(max_x(x0_reg, x1_reg));
    assign ya = clamp_y(min_y(y0_reg, y1_reg));
    assign yb = clamp_y(max_y(y0_reg, y1_reg));

    // ------------------------------------------------------------------
    // Pixel counter
    // ------------------------------------------------------------------
    logic       scan_load;
    logic       scan_en;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       scan_last;

    rect_scan_counter u_scan (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (scan_load),
        .enable (scan_en),
        .xa     (xa),
        .xb     (xb),
        .ya     (ya),
        .yb     (yb),
        .cx     (cx),
        .cy     (cy),
        .last   (scan_last)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        scan_load  = 1'b0;
        scan_en    = 1'b0;
        fill_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLIP;
                end
            end
            CLIP: begin
                scan_load  = 1'b1;
                state_next = FILL;
            end
            FILL: begin
                scan_en = 1'b1;
                if (scan_last) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The write strobe is registered alongside the counter so that
    // FB_ADDR, FB_DATA and FB_WE all change on the same edge.
    logic fb_we_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fb_we_reg <= 1'b0;
        end else begin
            fb_we_reg <= (state_next == FILL);
        end
    end

    assign FB_WE   = fb_we_reg;
    assign FB_ADDR = {cy, cx};
    assign FB_DATA = colour_reg;
    assign BUSY    = busy;

    // ------------------------------------------------------------------
    // Read path: sampled at the read edge, driven during the next cycle
    // ------------------------------------------------------------------
    logic [7:0] rd_data_next;
    logic [7:0] read_data_reg;
    logic       drive_reg;

    always_comb begin
        rd_data_next = 8'd0;
        case (offset)
            REG_X0:   rd_data_next = x0_reg;
            REG_Y0:   rd_data_next = {1'b0, y0_reg};
            REG_X1:   rd_data_next = x1_reg;
            REG_Y1:   rd_data_next = {1'b0, y1_reg};
            REG_CTRL: rd_data_next = {busy, done_reg, 5'b0, colour_reg};
            default:  rd_data_next = 8'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            read_data_reg <= 8'd0;
            drive_reg     <= 1'b0;
        end else begin
            drive_reg <= rd_en;
            if (rd_en) begin
                read_data_reg <= rd_data_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bus_drv
            assign BUS_DATA[gi] = drive_reg ? read_data_reg[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_vga_rect_fill.sv
module tb_vga_rect_fill;

    localparam logic [7:0] BASE = 8'hC0;

    logic        CLK;
    logic        RESET;
    wire  [7:0]  BUS_DATA;
    logic [7:0]  BUS_ADDR;
    logic        BUS_WE;
    logic [14:0] FB_ADDR;
    logic        FB_DATA;
    logic        FB_WE;
    logic        BUSY;

    logic [7:0]  tb_drive;
    logic        tb_oe;

    assign BUS_DATA = tb_oe ? tb_drive : 8'bz;

    // Weak pull-ups make a released bus read back as all ones.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pull
            pullup (BUS_DATA[gi]);
        end
    endgenerate

    vga_rect_fill #(.BaseAddr(BASE)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUS_DATA (BUS_DATA),
        .BUS_ADDR (BUS_ADDR),
        .BUS_WE   (BUS_WE),
        .FB_ADDR  (FB_ADDR),
        .FB_DATA  (FB_DATA),
        .FB_WE    (FB_WE),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int pix_cnt = 0;

    typedef struct packed {
        logic [14:0] addr;
        logic        data;
    } pix_t;

    pix_t exp_q[$];

    // Scoreboard monitor: every frame-buffer write must match the head of
    // the expected queue.
    always @(negedge CLK) begin
        if (FB_WE === 1'b1) begin
            pix_t e;
            pix_cnt = pix_cnt + 1;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pixel: got addr=%h data=%b, required no write", FB_ADDR, FB_DATA);
            end else begin
                e = exp_q.pop_front();
                if (FB_ADDR !== e.addr || FB_DATA !== e.data) begin
                    errors = errors + 1;
                    $display("FAIL pixel: got addr=%h data=%b, required addr=%h data=%b",
                             FB_ADDR, FB_DATA, e.addr, e.data);
                end else begin
                    $display("pixel y=%0d x=%0d data=%b ok", FB_ADDR[14:8], FB_ADDR[7:0], FB_DATA);
                end
            end
        end
    end

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge CLK);
        BUS_ADDR = addr;
        BUS_WE   = 1'b1;
        tb_drive = data;
        tb_oe    = 1'b1;
        @(posedge CLK);
        #1;
        BUS_WE   = 1'b0;
        BUS_ADDR = 8'h00;
        tb_oe    = 1'b0;
        $display("bus write addr=%h data=%h", addr, data);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge CLK);
        BUS_ADDR = addr;
        BUS_WE   = 1'b0;
        tb_oe    = 1'b0;
        @(posedge CLK);
        #1;
        BUS_ADDR = 8'h00;
        @(negedge CLK);
        data = BUS_DATA;
        $display("bus read addr=%h data=%h", addr, data);
    endtask

    task automatic push_rect(input int xa, input int xb, input int ya, input int yb, input logic c);
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                pix_t p;
                p.addr = {7'(y), 8'(x)};
                p.data = c;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (BUSY === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic program_rect(input logic [7:0] x0, input logic [7:0] y0,
                                input logic [7:0] x1, input logic [7:0] y1);
        bus_write(BASE + 8'd0, x0);
        bus_write(BASE + 8'd1, y0);
        bus_write(BASE + 8'd2, x1);
        bus_write(BASE + 8'd3, y1);
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (FB_WE !== 1'b0 || BUSY !== 1'b0 || FB_ADDR !== 15'd0 || FB_DATA !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b busy=%b addr=%h data=%b, required 0 0 0000 0",
                     FB_WE, BUSY, FB_ADDR, FB_DATA);
        end else $display("reset outputs ok");
        checks++;
        if (BUS_DATA !== 8'hFF) begin
            errors++;
            $display("FAIL reset_bus_released: got %h, required ff", BUS_DATA);
        end
        bus_read(BASE + 8'd4, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %h, required 00", rd);
        end
        bus_read(BASE + 8'd2, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL reset_x1: got %h, required 00", rd);
        end
    endtask

    task automatic test_basic();
        logic [7:0] rd;
        bit ok;
        pix_cnt = 0;
        program_rect(8'd2, 8'd3, 8'd4, 8'd4);
        push_rect(2, 4, 3, 4, 1'b1);
        bus_write(BASE + 8'd4, 8'h03);
        wait_idle(ok);
        checks++;
        if (!ok || pix_cnt != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count: got ok=%0d writes=%0d left=%0d, required 1 6 0", ok, pix_cnt, exp_q.size());
        end
        bus_read(BASE + 8'd4, rd);
        checks++;
        if (rd !== 8'h41) begin
            errors++;
            $display("FAIL basic_status: got %h, required 41", rd);
        end
        bus_read(BASE + 8'd1, rd);
        checks++;
        if (rd !== 8'h03) begin
            errors++;
            $display("FAIL basic_y0_readback: got %h, required 03", rd);
        end
    endtask

    task automatic test_swapped();
        logic [7:0] rd;
        bit ok;
        pix_cnt = 0;
        program_rect(8'd10, 8'd0, 8'd5, 8'd0);
        push_rect(5, 10, 0, 0, 1'b0);
        bus_write(BASE + 8'd4, 8'h02);
        wait_idle(ok);
        checks++;
        if (!ok || pix_cnt != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL swapped_count: got ok=%0d writes=%0d left=%0d, required 1 6 0", ok, pix_cnt, exp_q.size());
        end
        bus_read(BASE + 8'd4, rd);
        checks++;
        if (rd !== 8'h40) begin
            errors++;
            $display("FAIL swapped_status: got %h, required 40", rd);
        end
    endtask

    task automatic test_clamp();
        bit ok;
        pix_cnt = 0;
        program_rect(8'd150, 8'd118, 8'd200, 8'd127);
        push_rect(150, 159, 118, 119, 1'b1);
        bus_write(BASE + 8'd4, 8'h03);
        wait_idle(ok);
        checks++;
        if (!ok || pix_cnt != 20 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clamp_count: got ok=%0d writes=%0d left=%0d, required 1 20 0", ok, pix_cnt, exp_q.size());
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] rd;
        bit ok;
        pix_cnt = 0;
        program_rect(8'd1, 8'd0, 8'd4, 8'd1);
        push_rect(1, 4, 0, 1, 1'b1);
        bus_write(BASE + 8'd4, 8'h03);
        bus_write(BASE + 8'd0, 8'd0);
        bus_write(BASE + 8'd4, 8'h02);
        bus_read(BASE + 8'd4, rd);
        checks++;
        if (rd[7] !== 1'b1 || rd[6] !== 1'b0) begin
            errors++;
            $display("FAIL busy_status: got %h, required bit7=1 bit6=0", rd);
        end
        wait_idle(ok);
        repeat (3) @(negedge CLK);
        checks++;
        if (!ok || pix_cnt != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL busy_ignore_count: got ok=%0d writes=%0d left=%0d, required 1 8 0", ok, pix_cnt, exp_q.size());
        end
        bus_read(BASE + 8'd0, rd);
        checks++;
        if (rd !== 8'd1) begin
            errors++;
            $display("FAIL busy_x0_readback: got %h, required 01", rd);
        end
        bus_read(BASE + 8'd4, rd);
        checks++;
        if (rd !== 8'h41) begin
            errors++;
            $display("FAIL busy_end_status: got %h, required 41", rd);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [7:0] rd;
        bit seen;
        pix_cnt = 0;
        program_rect(8'd0, 8'd0, 8'd3, 8'd3);
        push_rect(0, 2, 0, 0, 1'b1);
        bus_write(BASE + 8'd4, 8'h03);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (FB_WE === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_first_pixel: got no write within 20 cycles, required a write");
        end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (FB_WE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got we=%b busy=%b, required 0 0", FB_WE, BUSY);
        end
        repeat (20) @(negedge CLK);
        checks++;
        if (pix_cnt != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_count: got writes=%0d left=%0d, required 3 0", pix_cnt, exp_q.size());
        end
        bus_read(BASE + 8'd4, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL midreset_status: got %h, required 00", rd);
        end
    endtask

    task automatic test_read_range();
        logic [7:0] rd;
        bit ok;
        // Load distinctive register contents so a stray drive would show.
        program_rect(8'h12, 8'h05, 8'h34, 8'h06);
        bus_read(BASE + 8'd5, rd);
        checks++;
        if (rd !== 8'hFF) begin
            errors++;
            $display("FAIL range_above: got %h, required released bus (ff)", rd);
        end
        bus_read(BASE - 8'd1, rd);
        checks++;
        if (rd !== 8'hFF) begin
            errors++;
            $display("FAIL range_below: got %h, required released bus (ff)", rd);
        end
        bus_read(BASE + 8'd2, rd);
        checks++;
        if (rd !== 8'h34) begin
            errors++;
            $display("FAIL range_x1: got %h, required 34", rd);
        end
        @(negedge CLK);
        checks++;
        if (BUS_DATA !== 8'hFF) begin
            errors++;
            $display("FAIL range_release_after_read: got %h, required ff", BUS_DATA);
        end
        // Single-pixel rectangle (corners equal).
        pix_cnt = 0;
        program_rect(8'd7, 8'd9, 8'd7, 8'd9);
        push_rect(7, 7, 9, 9, 1'b0);
        bus_write(BASE + 8'd4, 8'h02);
        wait_idle(ok);
        checks++;
        if (!ok || pix_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL degenerate_count: got ok=%0d writes=%0d left=%0d, required 1 1 0", ok, pix_cnt, exp_q.size());
        end
    endtask

    initial begin
        RESET    = 1'b1;
        BUS_ADDR = 8'h00;
        BUS_WE   = 1'b0;
        tb_drive = 8'h00;
        tb_oe    = 1'b0;
        test_reset();
        test_basic();
        test_swapped();
        test_clamp();
        test_busy_ignore();
        test_reset_mid_fill();
        test_read_range();
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
